// File: rtl/pe_array_sequencer_if.sv
// Command bus between the host, the pe_array_sequencer and the pe_array.
// The master side issues commands and answers with ready.
// The slave side is the sequencer.
interface pe_array_sequencer_if #(
  parameter int PRECISION        = 8,
  parameter int OUTPUT_PRECISION = 32,
  parameter int REP_W            = 4
);
  // host -> sequencer
  logic                        cmd_push;
  logic [2:0]                  cmd_opcode;
  logic [1:0]                  cmd_shift_dir;
  logic                        cmd_image;
  logic [REP_W-1:0]            cmd_repeat;
  logic [PRECISION-1:0]        cmd_a;
  logic [PRECISION-1:0]        cmd_b;
  logic [OUTPUT_PRECISION-1:0] cmd_s;
  logic                        cmd_full;
  logic                        cmd_empty;

  // sequencer <-> array
  logic [2:0]                  command_to_execute;
  logic [1:0]                  shift_direction;
  logic                        image_to_shift;
  logic [PRECISION-1:0]        a_overwrite;
  logic [PRECISION-1:0]        b_overwrite;
  logic [OUTPUT_PRECISION-1:0] s_out_overwrite;
  logic                        ready;
  logic                        array_ack;

  modport master (
    output cmd_push, cmd_opcode, cmd_shift_dir, cmd_image, cmd_repeat,
           cmd_a, cmd_b, cmd_s, ready,
    input  cmd_full, cmd_empty, command_to_execute, shift_direction,
           image_to_shift, a_overwrite, b_overwrite, s_out_overwrite, array_ack
  );

  modport slave (
    input  cmd_push, cmd_opcode, cmd_shift_dir, cmd_image, cmd_repeat,
           cmd_a, cmd_b, cmd_s, ready,
    output cmd_full, cmd_empty, command_to_execute, shift_direction,
           image_to_shift, a_overwrite, b_overwrite, s_out_overwrite, array_ack
  );
endinterface

// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: buffers host commands in a small FIFO and issues them
// one at a time to pe_array. Each command is held until ready, then
// acknowledged, and optionally repeated. The block also reports timeouts
// and FIFO overflow.
module pe_array_sequencer #(
  parameter int PRECISION        = 8,
  parameter int OUTPUT_PRECISION = 32,
  parameter int DEPTH            = 8,
  parameter int REP_W            = 4,
  parameter int TIMEOUT          = 256
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  pe_array_sequencer_if.slave    bus,
  input  logic                   enable,
  input  logic                   err_clr,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   overflow_err,
  output logic [15:0]            cmds_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic [2:0]                  op;
    logic [1:0]                  dir;
    logic                        img;
    logic [REP_W-1:0]            rep;
    logic [PRECISION-1:0]        a;
    logic [PRECISION-1:0]        b;
    logic [OUTPUT_PRECISION-1:0] s;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  entry_t                      mem [DEPTH];
  entry_t                      in_entry;
  entry_t                      head;
  logic [AW:0]                 wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic                        push_ok, pop, timed_out;
  state_t                      state, state_nxt;
  logic [REP_W-1:0]            rep_cnt;
  logic [TW-1:0]               timer;
  logic [2:0]                  cur_op;
  logic [1:0]                  cur_dir;
  logic                        cur_img;
  logic [PRECISION-1:0]        cur_a, cur_b;
  logic [OUTPUT_PRECISION-1:0] cur_s;

  assign in_entry = '{op: bus.cmd_opcode, dir: bus.cmd_shift_dir, img: bus.cmd_image,
                      rep: bus.cmd_repeat, a: bus.cmd_a, b: bus.cmd_b, s: bus.cmd_s};
  assign head     = mem[rd_ptr[AW-1:0]];
  // Full is judged on the registered flag, so a slot freed by a pop this cycle
  // is not reusable until the next cycle.
  assign push_ok  = bus.cmd_push && !bus.cmd_full;
  assign wr_nxt   = wr_ptr + (AW+1)'(push_ok);
  assign rd_nxt   = rd_ptr + (AW+1)'(pop);

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= in_entry;
  end

  // FIFO pointers and registered full/empty flags (wrap bit separates full from empty)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.cmd_empty <= 1'b1;
      bus.cmd_full  <= 1'b0;
    end else begin
      wr_ptr        <= wr_nxt;
      rd_ptr        <= rd_nxt;
      bus.cmd_empty <= (wr_nxt == rd_nxt);
      bus.cmd_full  <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end
  end

  // Next-state decode: pop in IDLE, wait for ready or timeout, then acknowledge
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !bus.cmd_empty) begin
          pop = 1'b1;
          if (head.op != 3'd0) state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.ready) begin
          state_nxt = ACK;
        end else if (timer == TMO_LAST) begin
          timed_out = 1'b1;
          state_nxt = IDLE;
        end
      end
      ACK:     state_nxt = (rep_cnt != '0) ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, held command fields, and registered array-side outputs.
  // The overwrite outputs keep their last value outside WAIT; only the opcode
  // returns to zero. Re-issue is driven directly from ACK, so repeats show a
  // single zero cycle between issues.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state                  <= IDLE;
      busy                   <= 1'b0;
      rep_cnt                <= '0;
      timer                  <= '0;
      cur_op                 <= '0;
      cur_dir                <= '0;
      cur_img                <= 1'b0;
      cur_a                  <= '0;
      cur_b                  <= '0;
      cur_s                  <= '0;
      cmds_done              <= '0;
      bus.array_ack          <= 1'b0;
      bus.command_to_execute <= '0;
      bus.shift_direction    <= '0;
      bus.image_to_shift     <= 1'b0;
      bus.a_overwrite        <= '0;
      bus.b_overwrite        <= '0;
      bus.s_out_overwrite    <= '0;
    end else begin
      state                  <= state_nxt;
      busy                   <= (state_nxt != IDLE);
      bus.array_ack          <= 1'b0;
      bus.command_to_execute <= 3'd0;
      case (state)
        IDLE: begin
          if (pop && head.op != 3'd0) begin
            cur_op  <= head.op;
            cur_dir <= head.dir;
            cur_img <= head.img;
            cur_a   <= head.a;
            cur_b   <= head.b;
            cur_s   <= head.s;
            rep_cnt <= head.rep;
            timer   <= '0;
          end
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (bus.ready) begin
            bus.array_ack <= 1'b1;
            cmds_done     <= cmds_done + 16'd1;
          end else if (timed_out) begin
            rep_cnt <= '0;
          end else begin
            bus.command_to_execute <= cur_op;
            bus.shift_direction    <= cur_dir;
            bus.image_to_shift     <= cur_img;
            bus.a_overwrite        <= cur_a;
            bus.b_overwrite        <= cur_b;
            bus.s_out_overwrite    <= cur_s;
          end
        end
        ACK: begin
          if (rep_cnt != '0) begin
            rep_cnt                <= rep_cnt - REP_W'(1);
            timer                  <= '0;
            bus.command_to_execute <= cur_op;
            bus.shift_direction    <= cur_dir;
            bus.image_to_shift     <= cur_img;
            bus.a_overwrite        <= cur_a;
            bus.b_overwrite        <= cur_b;
            bus.s_out_overwrite    <= cur_s;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky error flags; a set event in the same cycle as err_clr wins
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      timeout_err  <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (timed_out)    timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
      if (bus.cmd_push && bus.cmd_full) overflow_err <= 1'b1;
      else if (err_clr)                 overflow_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Testbench for pe_array_sequencer.
// Stimulus pushes the expected issues into a queue. A monitor pops and
// compares one entry on every array_ack. A responder plays pe_array by
// pulsing ready on the third cycle a command is visible.
module tb_pe_array_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        enable, err_clr;
  logic        busy, timeout_err, overflow_err;
  logic [15:0] cmds_done;

  pe_array_sequencer_if #(.PRECISION(8), .OUTPUT_PRECISION(32), .REP_W(4)) bus ();

  pe_array_sequencer #(
    .PRECISION(8), .OUTPUT_PRECISION(32), .DEPTH(8), .REP_W(4), .TIMEOUT(16)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus), .enable(enable), .err_clr(err_clr),
    .busy(busy), .timeout_err(timeout_err), .overflow_err(overflow_err),
    .cmds_done(cmds_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  dir;
    logic        img;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] s;
    bit          is_rep;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   resp_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [1:0] dir, input logic img,
                      input logic [3:0] rep, input logic [7:0] a, input logic [7:0] b,
                      input logic [31:0] s);
    bus.cmd_push      = 1'b1;
    bus.cmd_opcode    = op;
    bus.cmd_shift_dir = dir;
    bus.cmd_image     = img;
    bus.cmd_repeat    = rep;
    bus.cmd_a         = a;
    bus.cmd_b         = b;
    bus.cmd_s         = s;
    @(negedge CLK);
    bus.cmd_push      = 1'b0;
  endtask

  task automatic add_exp(input logic [2:0] op, input logic [1:0] dir, input logic img,
                         input logic [7:0] a, input logic [7:0] b, input logic [31:0] s,
                         input bit is_rep);
    exp_t e;
    e.op = op; e.dir = dir; e.img = img; e.a = a; e.b = b; e.s = s; e.is_rep = is_rep;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int maxc);
    bit done = 1'b0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < maxc; i++) begin
      if (!busy && bus.cmd_empty) begin
        done = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    chk("idle_reached", {63'd0, done}, 64'd1);
  endtask

  task automatic wait_cmd(input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge CLK);
      if (bus.command_to_execute != 3'd0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("cmd_visible", {63'd0, seen}, 64'd1);
  endtask

  task automatic pulse_err_clr();
    @(negedge CLK);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
  endtask

  // pe_array model: ready pulses on the third negedge a command has been visible
  initial begin : responder
    int rcnt;
    rcnt = 0;
    forever begin
      @(negedge CLK);
      bus.ready = 1'b0;
      if (resp_en && bus.command_to_execute != 3'd0) begin
        rcnt++;
        if (rcnt == 3) begin
          bus.ready = 1'b1;
          rcnt      = 0;
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  // Monitor: track the issued fields, hold length and zero gap; score each ack
  initial begin : monitor
    int          hold, zrun, gap;
    logic [2:0]  l_op;
    logic [1:0]  l_dir;
    logic        l_img;
    logic [7:0]  l_a, l_b;
    logic [31:0] l_s;
    exp_t        e;
    hold = 0; zrun = 1; gap = 0;
    l_op = '0; l_dir = '0; l_img = 1'b0; l_a = '0; l_b = '0; l_s = '0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        hold = 0;
        zrun = 1;
      end else begin
        if (bus.array_ack) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ack", {61'd0, l_op}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("ack_op", {61'd0, l_op}, {61'd0, e.op});
            chk("ack_a", {56'd0, l_a}, {56'd0, e.a});
            chk("ack_dir_img_b_s", {21'd0, l_dir, l_img, l_b, l_s},
                {21'd0, e.dir, e.img, e.b, e.s});
            chk("ack_hold_cycles", 64'(hold), 64'd3);
            chk("ack_cmd_zero", {61'd0, bus.command_to_execute}, 64'd0);
            if (e.is_rep) chk("repeat_gap", 64'(gap), 64'd1);
          end
        end
        if (bus.command_to_execute != 3'd0) begin
          if (zrun > 0) begin
            gap  = zrun;
            hold = 0;
          end
          hold++;
          zrun  = 0;
          l_op  = bus.command_to_execute;
          l_dir = bus.shift_direction;
          l_img = bus.image_to_shift;
          l_a   = bus.a_overwrite;
          l_b   = bus.b_overwrite;
          l_s   = bus.s_out_overwrite;
        end else begin
          zrun++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int nz;
    RST_N = 1'b1; enable = 1'b0; err_clr = 1'b0;
    bus.cmd_push = 1'b0; bus.cmd_opcode = '0; bus.cmd_shift_dir = '0; bus.cmd_image = 1'b0;
    bus.cmd_repeat = '0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_s = '0; bus.ready = 1'b0;
    #3 RST_N = 1'b0;
    repeat (3) @(negedge CLK);

    // reset state
    chk("rst_array_outs", {bus.command_to_execute, bus.shift_direction, bus.image_to_shift,
        bus.a_overwrite, bus.b_overwrite, bus.s_out_overwrite}, 64'd0);
    chk("rst_ctrl", {59'd0, bus.array_ack, busy, timeout_err, overflow_err, bus.cmd_full}, 64'd0);
    chk("rst_empty", {63'd0, bus.cmd_empty}, 64'd1);
    chk("rst_cmds_done", {48'd0, cmds_done}, 64'd0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_cmd_zero", {61'd0, bus.command_to_execute}, 64'd0);

    // single command, answered three cycles after issue
    enable = 1'b1; resp_en = 1'b1;
    add_exp(3'b001, 2'b01, 1'b0, 8'h11, 8'h22, 32'h0000_3333, 1'b0);
    push(3'b001, 2'b01, 1'b0, 4'd0, 8'h11, 8'h22, 32'h0000_3333);
    wait_idle(100);
    chk("t1_cmds_done", {48'd0, cmds_done}, 64'd1);
    chk("t1_busy", {63'd0, busy}, 64'd0);

    // repeat 2: three issues, three acks (cmds_done is cumulative: 1 + 3)
    add_exp(3'b010, 2'b10, 1'b1, 8'h5A, 8'hA5, 32'hDEAD_BEEF, 1'b0);
    add_exp(3'b010, 2'b10, 1'b1, 8'h5A, 8'hA5, 32'hDEAD_BEEF, 1'b1);
    add_exp(3'b010, 2'b10, 1'b1, 8'h5A, 8'hA5, 32'hDEAD_BEEF, 1'b1);
    push(3'b010, 2'b10, 1'b1, 4'd2, 8'h5A, 8'hA5, 32'hDEAD_BEEF);
    wait_idle(200);
    chk("t2_cmds_done", {48'd0, cmds_done}, 64'd4);

    // overflow: fill with enable low, ninth push dropped
    enable = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      add_exp(3'((i % 7) + 1), 2'(i % 4), 1'(i % 2), 8'(8'h30 + i), 8'(8'hC0 + i),
              32'(32'h1000 + i), 1'b0);
      push(3'((i % 7) + 1), 2'(i % 4), 1'(i % 2), 4'd0, 8'(8'h30 + i), 8'(8'hC0 + i),
           32'(32'h1000 + i));
    end
    chk("ovf_full_after_depth", {63'd0, bus.cmd_full}, 64'd1);
    chk("ovf_err_not_yet", {63'd0, overflow_err}, 64'd0);
    push(3'b111, 2'b11, 1'b1, 4'd0, 8'hFF, 8'hFF, 32'hFFFF_FFFF);
    chk("ovf_err_set", {63'd0, overflow_err}, 64'd1);
    chk("ovf_still_full", {63'd0, bus.cmd_full}, 64'd1);
    pulse_err_clr();
    chk("ovf_err_cleared", {63'd0, overflow_err}, 64'd0);
    enable = 1'b1;
    wait_idle(600);
    chk("t3_cmds_done", {48'd0, cmds_done}, 64'd12);

    // timeout: no ready, repeat 3 must not be issued
    resp_en = 1'b0;
    push(3'b011, 2'b00, 1'b0, 4'd3, 8'h77, 8'h00, 32'h0);
    wait_cmd(20);
    repeat (14) @(negedge CLK);
    chk("tmo_not_early", {63'd0, timeout_err}, 64'd0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge CLK);
        if (timeout_err) begin
          seen = 1'b1;
          chk("tmo_cmd_zero", {61'd0, bus.command_to_execute}, 64'd0);
          break;
        end
      end
      chk("tmo_err_set", {63'd0, seen}, 64'd1);
    end
    nz = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (bus.command_to_execute != 3'd0) nz++;
    end
    chk("tmo_no_repeat", 64'(nz), 64'd0);
    chk("tmo_no_count", {48'd0, cmds_done}, 64'd12);
    chk("tmo_busy_low", {63'd0, busy}, 64'd0);
    pulse_err_clr();
    chk("tmo_err_cleared", {63'd0, timeout_err}, 64'd0);

    // NOP skipping and a stray ready while idle
    enable = 1'b0;
    push(3'b000, 2'b00, 1'b0, 4'd0, 8'hEE, 8'hEE, 32'hEEEE_EEEE);
    push(3'b100, 2'b11, 1'b1, 4'd0, 8'h69, 8'h01, 32'h0000_0002);
    #1 bus.ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("stray_ready_ignored", {47'd0, busy, cmds_done}, {47'd0, 1'b0, 16'd12});
    add_exp(3'b100, 2'b11, 1'b1, 8'h69, 8'h01, 32'h0000_0002, 1'b0);
    resp_en = 1'b1;
    enable  = 1'b1;
    wait_idle(100);
    chk("t5_cmds_done", {48'd0, cmds_done}, 64'd13);

    // asynchronous reset while waiting, with three entries still queued
    resp_en = 1'b0;
    enable  = 1'b0;
    for (int i = 0; i < 4; i++) push(3'b101, 2'b01, 1'b1, 4'd1, 8'h42, 8'h24, 32'h5555);
    enable = 1'b1;
    wait_cmd(10);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_array_outs", {bus.command_to_execute, bus.shift_direction, bus.image_to_shift,
        bus.a_overwrite, bus.b_overwrite, bus.s_out_overwrite}, 64'd0);
    chk("arst_ctrl", {60'd0, bus.array_ack, busy, timeout_err, overflow_err}, 64'd0);
    chk("arst_fifo", {62'd0, bus.cmd_empty, bus.cmd_full}, 64'd2);
    chk("arst_cmds_done", {48'd0, cmds_done}, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    nz = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (bus.command_to_execute != 3'd0 || busy) nz++;
    end
    chk("arst_nothing_issued", 64'(nz), 64'd0);
    chk("arst_still_empty", {63'd0, bus.cmd_empty}, 64'd1);

    chk("all_expected_acked", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
